// File: rtl/spi_flash_reader.sv
// Purpose : SPI NOR READ (0x03) sequencer in front of a byte-level SPI master; owns chip-select.
// Latency : o_Data follows the byte master's i_RX_DV by one cycle; CS framing adds setup/hold/idle gaps.
// Backpress: byte issue waits on i_TX_Ready and on the previous byte returning; the consumer side has none.
//
// Ports:
//   i_Clk, i_Rst_L          clock, asynchronous active-low reset
//   i_Start/i_Addr/i_Len    transaction request (accepted only when idle and i_Len != 0)
//   o_Busy                  high from accepted start until the CS idle gap has elapsed
//   o_Data/o_Data_DV        returned flash bytes, one strobe per byte
//   o_Done                  one strobe on the cycle chip-select rises
//   o_TX_Byte/o_TX_DV       byte and send pulse to the byte master
//   i_TX_Ready              byte master can accept a byte
//   i_RX_DV/i_RX_Byte       byte master returned a byte
//   o_SPI_CS_n              flash chip-select, active low
module spi_flash_reader #(
  parameter int         LEN_W         = 16,
  parameter int         CS_SETUP_CLKS = 4,
  parameter int         CS_HOLD_CLKS  = 4,
  parameter int         CS_IDLE_CLKS  = 8,
  parameter logic [7:0] READ_CMD      = 8'h03
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Start,
  input  logic [23:0]      i_Addr,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic [7:0]       o_Data,
  output logic             o_Data_DV,
  output logic             o_Done,
  output logic [7:0]       o_TX_Byte,
  output logic             o_TX_DV,
  input  logic             i_TX_Ready,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  output logic             o_SPI_CS_n
);

  // Shared phase counter for setup, hold and idle gaps; all three must fit below 2^16.
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t           r_state;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_cmd_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;   // a byte is in flight at the byte master

  logic       w_issue;
  logic       w_rx;
  logic [7:0] w_cmd_byte;

  // The master's ready drops a cycle after a send, so r_pend is what blocks a back-to-back send.
  assign w_issue = i_TX_Ready && !r_pend;
  // Stray receive strobes with nothing outstanding are ignored.
  assign w_rx    = i_RX_DV && r_pend;

  always_comb begin
    w_cmd_byte = READ_CMD;
    case (r_cmd_idx)
      2'd0: w_cmd_byte = READ_CMD;
      2'd1: w_cmd_byte = r_addr[23:16];
      2'd2: w_cmd_byte = r_addr[15:8];
      2'd3: w_cmd_byte = r_addr[7:0];
      default: w_cmd_byte = READ_CMD;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_cmd_idx  <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      o_Busy     <= 1'b0;
      o_Data     <= '0;
      o_Data_DV  <= 1'b0;
      o_Done     <= 1'b0;
      o_TX_Byte  <= '0;
      o_TX_DV    <= 1'b0;
      o_SPI_CS_n <= 1'b1;
    end else begin
      o_TX_DV   <= 1'b0;
      o_Data_DV <= 1'b0;
      o_Done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start && (i_Len != '0)) begin
            r_addr     <= i_Addr;
            r_len      <= i_Len;
            r_cmd_idx  <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            o_SPI_CS_n <= 1'b0;
            o_Busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == CNT_W'(CS_SETUP_CLKS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_CMD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CMD: begin
          if (w_rx) begin
            // Bytes clocked in during the command phase carry no data.
            r_pend    <= 1'b0;
            r_cmd_idx <= r_cmd_idx + 2'd1;
            if (r_cmd_idx == 2'd3) r_state <= S_DATA;
          end else if (w_issue) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= w_cmd_byte;
            r_pend    <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_rx) begin
            r_pend    <= 1'b0;
            o_Data    <= i_RX_Byte;
            o_Data_DV <= 1'b1;
            r_len     <= r_len - 1'b1;
            // Leaving on the last byte keeps r_len from ever reaching below zero.
            if (r_len == LEN_W'(1)) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end
          end else if (w_issue) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= 8'h00;
            r_pend    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == CNT_W'(CS_HOLD_CLKS - 1)) begin
            r_cnt      <= '0;
            o_SPI_CS_n <= 1'b1;
            o_Done     <= 1'b1;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          // Counts a full CS_IDLE_CLKS cycles beyond the o_Done cycle.
          if (r_cnt == CNT_W'(CS_IDLE_CLKS)) begin
            o_Busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Purpose : self-checking bench for spi_flash_reader with a byte-master/flash model.
// Latency : n/a (bench).
// Backpress: the byte-master model drops ready one cycle after each send and returns bytes after a random delay.
module tb_spi_flash_reader;

  localparam int LEN_W  = 12;
  localparam int MAXLEN = (1 << LEN_W) - 1;

  logic             i_Clk = 1'b0;
  logic             i_Rst_L = 1'b1;
  logic             i_Start = 1'b0;
  logic [23:0]      i_Addr = '0;
  logic [LEN_W-1:0] i_Len = '0;
  logic             o_Busy;
  logic [7:0]       o_Data;
  logic             o_Data_DV;
  logic             o_Done;
  logic [7:0]       o_TX_Byte;
  logic             o_TX_DV;
  logic             i_TX_Ready;
  logic             i_RX_DV;
  logic [7:0]       i_RX_Byte;
  logic             o_SPI_CS_n;

  always #5 i_Clk = ~i_Clk;

  spi_flash_reader #(.LEN_W(LEN_W)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Addr(i_Addr), .i_Len(i_Len),
    .o_Busy(o_Busy), .o_Data(o_Data), .o_Data_DV(o_Data_DV), .o_Done(o_Done),
    .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte), .o_SPI_CS_n(o_SPI_CS_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input longint act, input longint min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // Flash contents: a fixed scramble of the byte address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'hC3;
  endfunction

  // ---------------- byte master + flash model ----------------
  bit         m_busy = 0, rx_now = 0, fast = 0;
  int         m_wait = 0, proto_err = 0, fl_idx = 0;
  logic [7:0] m_tx, m_resp;
  logic [23:0] fl_addr = '0;
  logic [7:0] mosi_q[$];
  logic       prev_rdy;
  bit         was_rx;

  initial begin
    i_TX_Ready = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    forever begin
      @(posedge i_Clk);
      prev_rdy = i_TX_Ready;
      #1;
      if (!i_Rst_L) begin
        m_busy = 0; rx_now = 0; i_RX_DV = 1'b0; i_TX_Ready = 1'b1; fl_idx = 0;
      end else begin
        was_rx = rx_now;
        if (rx_now) begin i_RX_DV = 1'b0; i_TX_Ready = 1'b1; rx_now = 0; end
        if (o_SPI_CS_n) begin fl_idx = 0; fl_addr = '0; end
        if (o_TX_DV) begin
          if (!prev_rdy || m_busy || was_rx) proto_err++;
          m_busy = 1; m_tx = o_TX_Byte;
          m_wait = fast ? 0 : int'($urandom_range(0, 3));
          mosi_q.push_back(o_TX_Byte);
          if (fl_idx < 4) begin
            m_resp = 8'($urandom);
            if (fl_idx > 0) fl_addr = {fl_addr[15:0], o_TX_Byte};
          end else begin
            m_resp = mem_byte(fl_addr);
            fl_addr = fl_addr + 24'd1;
          end
          fl_idx++;
        end else if (m_busy) begin
          i_TX_Ready = 1'b0;
          if (o_TX_Byte != m_tx) proto_err++;
          if (m_wait == 0) begin
            i_RX_DV = 1'b1; i_RX_Byte = m_resp; m_busy = 0; rx_now = 1;
          end else begin
            m_wait--;
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  int cyc = 0, done_cnt = 0, cs_falls = 0, cs_rises = 0, tx_cnt = 0;
  int cs_fall_c = 0, first_tx_c = -1, last_rx_c = 0, cs_rise_c = 0, done_c = 0, busy_fall_c = 0;
  bit busy_seen = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;
  logic [7:0] got_q[$];

  initial begin
    forever begin
      @(negedge i_Clk);
      cyc++;
      if (prev_cs && !o_SPI_CS_n) begin cs_falls++; cs_fall_c = cyc; end
      if (!prev_cs && o_SPI_CS_n) begin cs_rises++; cs_rise_c = cyc; end
      if (o_TX_DV) begin tx_cnt++; if (first_tx_c < 0) first_tx_c = cyc; end
      if (i_RX_DV) last_rx_c = cyc;
      if (o_Data_DV) got_q.push_back(o_Data);
      if (o_Done) begin done_cnt++; done_c = cyc; end
      if (o_Busy) busy_seen = 1;
      if (prev_busy && !o_Busy) busy_fall_c = cyc;
      prev_cs = o_SPI_CS_n; prev_busy = o_Busy;
    end
  end

  task automatic clear_mon();
    got_q.delete(); mosi_q.delete();
    done_cnt = 0; cs_falls = 0; cs_rises = 0; tx_cnt = 0; first_tx_c = -1;
    proto_err = 0; busy_seen = 0;
  endtask

  task automatic pulse_start(input logic [23:0] addr, input int len);
    @(posedge i_Clk); #1;
    i_Start = 1'b1; i_Addr = addr; i_Len = LEN_W'(len);
    @(posedge i_Clk); #1;
    // Scramble the request lines so a late capture would show up.
    i_Start = 1'b0; i_Addr = 24'($urandom); i_Len = LEN_W'($urandom);
  endtask

  // Runs one request and checks everything observable against the model.
  task automatic run_xfer(input logic [23:0] addr, input int len, input int exp_dv,
                          input int exp_done, input bit inject);
    logic [7:0] exp_mosi[$];
    int bad, n;
    bit injected;
    clear_mon();
    exp_mosi.delete();
    if (exp_done != 0) begin
      exp_mosi = {8'h03, addr[23:16], addr[15:8], addr[7:0]};
      for (int i = 0; i < len; i++) exp_mosi.push_back(8'h00);
    end
    pulse_start(addr, len);
    n = 0; injected = 0;
    while (o_Busy && n < 8 * (len + 4) + 100) begin
      @(posedge i_Clk); #1;
      if (inject && !injected && got_q.size() >= 1) begin
        i_Start = 1'b1; i_Addr = 24'h000000; i_Len = LEN_W'(5); injected = 1;
      end else begin
        i_Start = 1'b0;
      end
      n++;
    end
    i_Start = 1'b0;
    chk("xfer_timeout_busy", o_Busy, 0);
    repeat (20) @(posedge i_Clk);
    @(negedge i_Clk); #1;

    chk("data_count", got_q.size(), exp_dv);
    bad = 0;
    for (int i = 0; i < got_q.size() && i < len; i++)
      if (got_q[i] != mem_byte(24'(addr + 24'(i)))) bad++;
    chk("data_bytes_bad", bad, 0);
    chk("mosi_count", mosi_q.size(), exp_mosi.size());
    bad = 0;
    for (int i = 0; i < mosi_q.size() && i < exp_mosi.size(); i++)
      if (mosi_q[i] != exp_mosi[i]) bad++;
    chk("mosi_bytes_bad", bad, 0);
    chk("done_count", done_cnt, exp_done);
    chk("cs_falls", cs_falls, exp_done);
    chk("cs_rises", cs_rises, exp_done);
    chk("busy_seen", busy_seen, exp_done);
    chk("protocol_errors", proto_err, 0);
    if (exp_done != 0) begin
      chk_ge("cs_setup_clks", first_tx_c - cs_fall_c, 4);
      chk_ge("cs_hold_clks", cs_rise_c - last_rx_c, 4);
      chk("done_at_cs_rise", done_c, cs_rise_c);
      chk_ge("busy_after_done", busy_fall_c - done_c - 1, 8);
    end else begin
      chk("tx_count_idle", tx_cnt, 0);
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          exp_dv;
    int          exp_done;
    bit          inject;
    bit          fast;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int len;
    logic [23:0] a;
    bit got_two;

    vecs[0] = '{24'h123456, 4,      4,      1, 0, 0};
    vecs[1] = '{24'h000000, 0,      0,      0, 0, 0};
    vecs[2] = '{24'h800000, 6,      6,      1, 1, 0};
    vecs[3] = '{24'hFFFFFE, 3,      3,      1, 0, 0};
    vecs[4] = '{24'h00ABCD, 1,      1,      1, 0, 0};
    vecs[5] = '{24'h3C3C3C, MAXLEN, MAXLEN, 1, 0, 1};

    #1 i_Rst_L = 1'b0;
    #24;
    chk("rst_cs_n", o_SPI_CS_n, 1);
    chk("rst_busy", o_Busy, 0);
    chk("rst_tx_dv", o_TX_DV, 0);
    chk("rst_data_dv", o_Data_DV, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_tx_byte", o_TX_Byte, 0);
    chk("rst_data", o_Data, 0);
    @(posedge i_Clk); #1 i_Rst_L = 1'b1;
    repeat (2) @(posedge i_Clk);

    for (int v = 0; v < 6; v++) begin
      fast = vecs[v].fast;
      run_xfer(vecs[v].addr, vecs[v].len, vecs[v].exp_dv, vecs[v].exp_done, vecs[v].inject);
    end
    fast = 0;

    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 16));
      a = 24'($urandom);
      run_xfer(a, len, len, 1, 1'($urandom_range(0, 1)) && len >= 4);
    end

    // Reset in the middle of the data phase.
    clear_mon();
    pulse_start(24'hABCDEF, 8);
    got_two = 0;
    for (int n = 0; n < 500 && !got_two; n++) begin
      @(posedge i_Clk); #1;
      if (got_q.size() >= 2) got_two = 1;
    end
    chk("rst_mid_reached_data", got_two, 1);
    i_Rst_L = 1'b0;
    #1;
    chk("rst_mid_cs_n", o_SPI_CS_n, 1);
    chk("rst_mid_busy", o_Busy, 0);
    chk("rst_mid_tx_dv", o_TX_DV, 0);
    chk("rst_mid_data_dv", o_Data_DV, 0);
    chk("rst_mid_done", o_Done, 0);
    chk("rst_mid_tx_byte", o_TX_Byte, 0);
    chk("rst_mid_data", o_Data, 0);
    repeat (3) @(posedge i_Clk);
    chk("rst_mid_no_done", done_cnt, 0);
    #1 i_Rst_L = 1'b1;
    repeat (2) @(posedge i_Clk);
    run_xfer(24'h000000, 2, 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
